// File: rtl/bus_pin_mux_pkg.sv
// rtl/bus_pin_mux_pkg.sv - shared types, beat-count helpers and pin constants for bus_pin_mux
package bus_pin_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic PIN_RW_READ  = 1'b1;
    localparam logic PIN_RW_WRITE = 1'b0;

    function automatic int abeats(input int addr_w, input int pin_w);
        return addr_w / pin_w;
    endfunction

    function automatic int dbeats(input int data_w, input int pin_w);
        return data_w / pin_w;
    endfunction

    // A single-beat bus still needs a one-bit phase port.
    function automatic int phase_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_pin_mux_if.sv
// rtl/bus_pin_mux_if.sv - core handshake, response channel and pin group of bus_pin_mux
interface bus_pin_mux_if
    import bus_pin_mux_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int PIN_W  = 8
);
    localparam int PH_W = phase_w(abeats(ADDR_W, PIN_W) + dbeats(DATA_W, PIN_W));

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [PIN_W-1:0]  pin_out;
    logic              pin_ale;
    logic [PH_W-1:0]   pin_phase;
    logic              pin_rw;
    logic [PIN_W-1:0]  pin_io_in;
    logic [PIN_W-1:0]  pin_io_out;
    logic [PIN_W-1:0]  pin_io_oe;
    logic              ext_rdy;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, pin_io_in, ext_rdy,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, pin_out, pin_ale,
               pin_phase, pin_rw, pin_io_out, pin_io_oe, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, pin_io_in, ext_rdy,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, pin_out, pin_ale,
               pin_phase, pin_rw, pin_io_out, pin_io_oe, busy
    );

endinterface

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - consecutive wait-state counter with terminal-count expiry
module bus_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    localparam int CW = (WAIT_MAX <= 1) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CW-1:0] TC = CW'(WAIT_MAX - 1);

    logic [CW-1:0] r_cnt;

    // Expiry fires on the wait cycle that would make the count reach WAIT_MAX.
    assign o_expire = (WAIT_MAX != 0) && i_inc && (r_cnt == TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bus_pin_mux.sv
// rtl/bus_pin_mux.sv - multiplexes wide address/data over a narrow pin group
// optional macro BUS_HIADDR_CACHE_EN: skip repeated upper address chunks
module bus_pin_mux
    import bus_pin_mux_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int PIN_W    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_pin_mux_if.slave  bus
);
    localparam int ABEATS = abeats(ADDR_W, PIN_W);
    localparam int DBEATS = dbeats(DATA_W, PIN_W);
    localparam int PH_W   = phase_w(ABEATS + DBEATS);
    localparam int HI_W   = (ABEATS > 1) ? ADDR_W - PIN_W : 1;
    localparam logic [PH_W-1:0] LAST_ABEAT = PH_W'(ABEATS - 1);
    localparam logic [PH_W-1:0] LAST_BEAT  = PH_W'(ABEATS + DBEATS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_we;
    logic              r_err;
    logic [PH_W-1:0]   r_beat;

    logic w_accept;
    logic w_hit;
    logic w_in_data;
    logic w_expire;
    logic w_timeout;
    logic w_on_bus;

    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid;
    assign w_in_data = (r_state == ST_DATA);
    assign w_timeout = w_in_data && !bus.ext_rdy && w_expire;
    assign w_on_bus  = (r_state == ST_ADDR) || w_in_data;

    bus_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_in_data || bus.ext_rdy),
        .i_inc    (w_in_data && !bus.ext_rdy),
        .o_expire (w_expire)
    );

`ifdef BUS_HIADDR_CACHE_EN
    logic [HI_W-1:0] r_hi;
    logic            r_hi_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_hi_vld <= 1'b0;
        end else if (w_timeout) begin
            r_hi_vld <= 1'b0;
        end else if (w_accept) begin
            r_hi     <= bus.req_addr[ADDR_W-1 -: HI_W];
            r_hi_vld <= 1'b1;
        end
    end

    assign w_hit = (ABEATS > 1) && r_hi_vld && (bus.req_addr[ADDR_W-1 -: HI_W] == r_hi);
`else
    assign w_hit = 1'b0;
`endif

    // Address and write data shift left each beat so the outgoing chunk is always the top slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr  <= w_hit ? (bus.req_addr << ((ABEATS - 1) * PIN_W)) : bus.req_addr;
                        r_beat  <= w_hit ? LAST_ABEAT : '0;
                        r_wdata <= bus.req_wdata;
                        r_we    <= bus.req_we;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_addr <= r_addr << PIN_W;
                    r_beat <= r_beat + PH_W'(1);
                    if (r_beat == LAST_ABEAT) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.ext_rdy) begin
                        if (r_we) begin
                            r_wdata <= r_wdata << PIN_W;
                        end else begin
                            r_rdata <= (r_rdata << PIN_W) | DATA_W'(bus.pin_io_in);
                        end
                        r_beat <= r_beat + PH_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= ST_RESP;
                        end
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_beat  <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_err    = (r_state == ST_RESP) && r_err;
    assign bus.rsp_rdata  = ((r_state == ST_RESP) && !r_err) ? r_rdata : '0;

    assign bus.pin_out    = (r_state == ST_ADDR) ? r_addr[ADDR_W-1 -: PIN_W] : '0;
    assign bus.pin_ale    = (r_state == ST_ADDR);
    assign bus.pin_phase  = w_on_bus ? r_beat : '0;
    assign bus.pin_rw     = (w_on_bus && r_we) ? PIN_RW_WRITE : PIN_RW_READ;
    assign bus.pin_io_oe  = (w_in_data && r_we) ? '1 : '0;
    assign bus.pin_io_out = (w_in_data && r_we) ? r_wdata[DATA_W-1 -: PIN_W] : '0;

endmodule

// File: tb/tb_bus_pin_mux.sv
// tb/tb_bus_pin_mux.sv - directed self-checking bench for bus_pin_mux
module tb_bus_pin_mux;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bus_pin_mux_if #(.ADDR_W(16), .DATA_W(8), .PIN_W(8)) u_bus ();

    bus_pin_mux #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .PIN_W    (8),
        .WAIT_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req_ready"}, 32'(u_bus.req_ready), 32'h1);
        chk({tag, ".busy"},      32'(u_bus.busy),      32'h0);
        chk({tag, ".rsp_valid"}, 32'(u_bus.rsp_valid), 32'h0);
        chk({tag, ".pin_ale"},   32'(u_bus.pin_ale),   32'h0);
        chk({tag, ".pin_out"},   32'(u_bus.pin_out),   32'h0);
        chk({tag, ".pin_io_oe"}, 32'(u_bus.pin_io_oe), 32'h0);
        chk({tag, ".pin_phase"}, 32'(u_bus.pin_phase), 32'h0);
        chk({tag, ".pin_rw"},    32'(u_bus.pin_rw),    32'h1);
    endtask

    initial begin
        rst_n             = 1'b0;
        u_bus.req_valid   = 1'b0;
        u_bus.req_we      = 1'b0;
        u_bus.req_addr    = 16'h0;
        u_bus.req_wdata   = 8'h0;
        u_bus.pin_io_in   = 8'h0;
        u_bus.ext_rdy     = 1'b1;
        cyc();
        cyc();
        chk_idle("reset");
        chk("reset.rsp_rdata", 32'(u_bus.rsp_rdata), 32'h0);
        chk("reset.rsp_err",   32'(u_bus.rsp_err),   32'h0);

        // Read 0x1234, data 0xA5, no waits
        rst_n           = 1'b1;
        u_bus.req_valid = 1'b1;
        u_bus.req_we    = 1'b0;
        u_bus.req_addr  = 16'h1234;
        cyc();
        u_bus.req_valid = 1'b0;
        chk("rd.c1.pin_out",   32'(u_bus.pin_out),   32'h12);
        chk("rd.c1.pin_ale",   32'(u_bus.pin_ale),   32'h1);
        chk("rd.c1.pin_phase", 32'(u_bus.pin_phase), 32'h0);
        chk("rd.c1.pin_rw",    32'(u_bus.pin_rw),    32'h1);
        chk("rd.c1.busy",      32'(u_bus.busy),      32'h1);
        cyc();
        chk("rd.c2.pin_out",   32'(u_bus.pin_out),   32'h34);
        chk("rd.c2.pin_phase", 32'(u_bus.pin_phase), 32'h1);
        u_bus.pin_io_in = 8'hA5;
        cyc();
        chk("rd.c3.pin_ale",   32'(u_bus.pin_ale),   32'h0);
        chk("rd.c3.pin_io_oe", 32'(u_bus.pin_io_oe), 32'h0);
        chk("rd.c3.pin_phase", 32'(u_bus.pin_phase), 32'h2);
        chk("rd.c3.rsp_valid", 32'(u_bus.rsp_valid), 32'h0);
        cyc();
        chk("rd.c4.rsp_valid", 32'(u_bus.rsp_valid), 32'h1);
        chk("rd.c4.rsp_rdata", 32'(u_bus.rsp_rdata), 32'hA5);
        chk("rd.c4.rsp_err",   32'(u_bus.rsp_err),   32'h0);
        cyc();
        chk_idle("rd.c5");

        // Write 0xBEEF <- 0x5A; request fields scrambled after acceptance
        u_bus.req_valid = 1'b1;
        u_bus.req_we    = 1'b1;
        u_bus.req_addr  = 16'hBEEF;
        u_bus.req_wdata = 8'h5A;
        cyc();
        u_bus.req_addr  = 16'h0000;
        u_bus.req_wdata = 8'h00;
        chk("wr.c1.req_ready", 32'(u_bus.req_ready), 32'h0);
        chk("wr.c1.pin_out",   32'(u_bus.pin_out),   32'hBE);
        chk("wr.c1.pin_rw",    32'(u_bus.pin_rw),    32'h0);
        cyc();
        u_bus.req_valid = 1'b0;
        chk("wr.c2.pin_out",    32'(u_bus.pin_out),    32'hEF);
        chk("wr.c2.pin_rw",     32'(u_bus.pin_rw),     32'h0);
        chk("wr.c2.pin_io_oe",  32'(u_bus.pin_io_oe),  32'h0);
        cyc();
        chk("wr.c3.pin_io_oe",  32'(u_bus.pin_io_oe),  32'hFF);
        chk("wr.c3.pin_io_out", 32'(u_bus.pin_io_out), 32'h5A);
        chk("wr.c3.pin_rw",     32'(u_bus.pin_rw),     32'h0);
        cyc();
        chk("wr.c4.rsp_valid",  32'(u_bus.rsp_valid),  32'h1);
        chk("wr.c4.rsp_rdata",  32'(u_bus.rsp_rdata),  32'h0);
        chk("wr.c4.pin_io_oe",  32'(u_bus.pin_io_oe),  32'h0);
        cyc();
        chk_idle("wr.c5");

        // Read 0x0F0F with three wait cycles; junk on pins while not ready
        u_bus.req_valid = 1'b1;
        u_bus.req_we    = 1'b0;
        u_bus.req_addr  = 16'h0F0F;
        cyc();
        u_bus.req_valid = 1'b0;
        cyc();
        cyc();
        u_bus.ext_rdy   = 1'b0;
        u_bus.pin_io_in = 8'hFF;
        cyc();
        cyc();
        chk("wt.c5.pin_phase", 32'(u_bus.pin_phase), 32'h2);
        chk("wt.c5.busy",      32'(u_bus.busy),      32'h1);
        cyc();
        u_bus.ext_rdy   = 1'b1;
        u_bus.pin_io_in = 8'h3C;
        chk("wt.c6.rsp_valid", 32'(u_bus.rsp_valid), 32'h0);
        chk("wt.c6.pin_phase", 32'(u_bus.pin_phase), 32'h2);
        cyc();
        chk("wt.c7.rsp_valid", 32'(u_bus.rsp_valid), 32'h1);
        chk("wt.c7.rsp_rdata", 32'(u_bus.rsp_rdata), 32'h3C);
        chk("wt.c7.rsp_err",   32'(u_bus.rsp_err),   32'h0);
        cyc();

        // Timeout: WAIT_MAX=4, ext_rdy held low
        u_bus.req_valid = 1'b1;
        u_bus.req_addr  = 16'h0001;
        u_bus.pin_io_in = 8'h99;
        cyc();
        u_bus.req_valid = 1'b0;
        cyc();
        cyc();
        u_bus.ext_rdy = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("to.c6.rsp_valid", 32'(u_bus.rsp_valid), 32'h0);
        cyc();
        chk("to.c7.rsp_valid", 32'(u_bus.rsp_valid), 32'h1);
        chk("to.c7.rsp_err",   32'(u_bus.rsp_err),   32'h1);
        chk("to.c7.rsp_rdata", 32'(u_bus.rsp_rdata), 32'h0);
        u_bus.ext_rdy = 1'b1;
        cyc();
        chk_idle("to.c8");

        // Normal read right after the timeout
        u_bus.req_valid = 1'b1;
        u_bus.req_addr  = 16'h4321;
        u_bus.pin_io_in = 8'h77;
        cyc();
        u_bus.req_valid = 1'b0;
        chk("ar.c1.pin_out", 32'(u_bus.pin_out), 32'h43);
        cyc();
        cyc();
        cyc();
        chk("ar.c4.rsp_valid", 32'(u_bus.rsp_valid), 32'h1);
        chk("ar.c4.rsp_rdata", 32'(u_bus.rsp_rdata), 32'h77);
        chk("ar.c4.rsp_err",   32'(u_bus.rsp_err),   32'h0);
        cyc();

        // Asynchronous reset during the second address beat
        u_bus.req_valid = 1'b1;
        u_bus.req_addr  = 16'h1234;
        cyc();
        u_bus.req_valid = 1'b0;
        cyc();
        chk("rs.c2.pin_ale", 32'(u_bus.pin_ale), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("rs.async");
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_idle("rs.release");

        // High-address reuse: 0x1234 then 0x1256
        u_bus.req_valid = 1'b1;
        u_bus.req_addr  = 16'h1234;
        u_bus.pin_io_in = 8'hA5;
        cyc();
        u_bus.req_valid = 1'b0;
        chk("hc1.c1.pin_out", 32'(u_bus.pin_out), 32'h12);
        cyc();
        cyc();
        cyc();
        chk("hc1.c4.rsp_valid", 32'(u_bus.rsp_valid), 32'h1);
        cyc();
        u_bus.req_valid = 1'b1;
        u_bus.req_addr  = 16'h1256;
        u_bus.pin_io_in = 8'h42;
        cyc();
        u_bus.req_valid = 1'b0;
`ifdef BUS_HIADDR_CACHE_EN
        chk("hc2.c1.pin_out",   32'(u_bus.pin_out),   32'h56);
        chk("hc2.c1.pin_phase", 32'(u_bus.pin_phase), 32'h1);
        cyc();
        chk("hc2.c2.pin_phase", 32'(u_bus.pin_phase), 32'h2);
        cyc();
        chk("hc2.c3.rsp_valid", 32'(u_bus.rsp_valid), 32'h1);
        chk("hc2.c3.rsp_rdata", 32'(u_bus.rsp_rdata), 32'h42);
`else
        chk("hc2.c1.pin_out",   32'(u_bus.pin_out),   32'h12);
        chk("hc2.c1.pin_phase", 32'(u_bus.pin_phase), 32'h0);
        cyc();
        chk("hc2.c2.pin_out",   32'(u_bus.pin_out),   32'h56);
        chk("hc2.c2.pin_phase", 32'(u_bus.pin_phase), 32'h1);
        cyc();
        chk("hc2.c3.rsp_valid", 32'(u_bus.rsp_valid), 32'h0);
        cyc();
        chk("hc2.c4.rsp_valid", 32'(u_bus.rsp_valid), 32'h1);
        chk("hc2.c4.rsp_rdata", 32'(u_bus.rsp_rdata), 32'h42);
`endif
        cyc();
        chk_idle("end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
